// File: rtl/exec_core.sv
// exec_core: sequential execute stage owning A, B, IP, CF, ZF and the OUT port.
//   Accepts one decoded instruction per instr_valid/instr_ready handshake.
//   Ports: clk, rst_n (async, active-low); instr_valid/instr_ready, opcode, imm, sw (instruction side);
//   ip (fetch address); a, b, cf, zf (architectural state); out_data/out_valid/out_ready (output port).
//   Optional macro EXEC_SHIFT_EN builds the multi-cycle SHL_A/SHR_A and the SHIFT state;
//   without it 0x13/0x14 behave as single-cycle NOPs.
module exec_core #(
  parameter int DATA_W = 8,
  parameter int IN_W   = 4,
  parameter int IP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] imm,
  input  logic [IN_W-1:0]   sw,
  output logic [IP_W-1:0]   ip,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              cf,
  output logic              zf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
`ifdef EXEC_SHIFT_EN
  localparam int SW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, OUT_WAIT} state_t;
`else
  typedef enum logic {IDLE, OUT_WAIT} state_t;
`endif
  state_t state, state_n;
  logic accept, is_out;
  logic [IP_W-1:0] jt, ip_n;
  logic [DATA_W-1:0] a_n, b_n;
  logic cf_n, zf_n;
  assign accept = instr_valid & instr_ready;
  assign is_out = opcode == 5'h09 || opcode == 5'h0B;
  assign jt = IP_W'(imm);
`ifdef EXEC_SHIFT_EN
  logic [SW-1:0] cnt, sh_n;
  logic dir, start_shift, sh_out;
  logic [DATA_W-1:0] a_sh;
  assign sh_n = imm[SW-1:0];
  assign start_shift = (opcode == 5'h13 || opcode == 5'h14) && sh_n != '0;
  // dir=1 shifts right; sh_out is the bit leaving a on this shift cycle
  assign a_sh = dir ? a >> 1 : a << 1;
  assign sh_out = dir ? a[0] : a[DATA_W-1];
`endif
  // Result of the instruction at the accept edge; flags clear unless the op sets them
  always_comb begin
    a_n = a;
    b_n = b;
    ip_n = ip + IP_W'(1);
    cf_n = 1'b0;
    zf_n = 1'b0;
    case (opcode)
      5'h00: begin {cf_n, a_n} = {1'b0, a} + {1'b0, imm}; zf_n = a_n == '0; end
      5'h01: a_n = b;
      5'h02: a_n = {a[DATA_W-1:IN_W], sw};
      5'h03: a_n = imm;
      5'h04: b_n = a;
      5'h05: begin {cf_n, b_n} = {1'b0, b} + {1'b0, imm}; zf_n = b_n == '0; end
      5'h06: b_n = {b[DATA_W-1:IN_W], sw};
      5'h07: b_n = imm;
      5'h0E: if (!cf) ip_n = jt;
      5'h0F: ip_n = jt;
      // borrow appears as the extra top bit of the widened difference
      5'h10: begin {cf_n, a_n} = {1'b0, a} - {1'b0, imm}; zf_n = a_n == '0; end
      5'h11: begin {cf_n, b_n} = {1'b0, b} - {1'b0, imm}; zf_n = b_n == '0; end
      5'h12: begin {cf_n, a_n} = {1'b0, a} + {1'b0, b}; zf_n = a_n == '0; end
      5'h15: if (zf) ip_n = jt;
`ifdef EXEC_SHIFT_EN
      // a zero-length shift completes here; longer shifts write flags on their last cycle
      5'h13, 5'h14: zf_n = !start_shift && a == '0;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
`ifdef EXEC_SHIFT_EN
      IDLE:     state_n = !accept ? IDLE : is_out ? OUT_WAIT : start_shift ? SHIFT : IDLE;
      SHIFT:    state_n = cnt == SW'(1) ? IDLE : SHIFT;
`else
      IDLE:     state_n = accept && is_out ? OUT_WAIT : IDLE;
`endif
      OUT_WAIT: state_n = out_ready ? IDLE : OUT_WAIT;
      default:  state_n = IDLE;
    endcase
  end
  always_comb instr_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      ip <= '0;
      cf <= 1'b0;
      zf <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
`ifdef EXEC_SHIFT_EN
      cnt <= '0;
      dir <= 1'b0;
`endif
    end else if (accept) begin
      a <= a_n;
      b <= b_n;
      ip <= ip_n;
      cf <= cf_n;
      zf <= zf_n;
      if (is_out) begin
        out_data <= opcode[1] ? imm : b;
        out_valid <= 1'b1;
      end
`ifdef EXEC_SHIFT_EN
      cnt <= sh_n;
      dir <= opcode[2];
`endif
    end
`ifdef EXEC_SHIFT_EN
    else if (state == SHIFT) begin
      a <= a_sh;
      cnt <= cnt - SW'(1);
      if (cnt == SW'(1)) begin
        cf <= sh_out;
        zf <= a_sh == '0;
      end
    end
`endif
    else if (out_valid && out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed table, hand-written corner sequences and a randomized run against a reference model.
module tb_exec_core;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] opcode = '0;
  logic [7:0] imm = '0;
  logic [3:0] sw = '0;
  logic instr_ready, cf, zf, out_valid;
  logic [7:0] ip, a, b, out_data;
  int n_pass = 0, n_tot = 0;
  int ma = 0, mb = 0, mip = 0, mcf = 0, mzf = 0;

  exec_core #(.DATA_W(8), .IN_W(4), .IP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .imm(imm), .sw(sw), .ip(ip), .a(a), .b(b), .cf(cf), .zf(zf),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  // Reference model: arithmetic on integers straight from the instruction definitions.
  // Returns the number of extra busy cycles (shift length), 0 otherwise.
  function automatic int model(input int op, input int im, input int s);
    int r, n, ocf, ozf, cyc;
    ocf = 0; ozf = 0; cyc = 0;
    r = 0; n = 0;
    case (op)
      'h00: begin r = ma + im; ocf = r > 255 ? 1 : 0; ma = r % 256; ozf = ma == 0 ? 1 : 0; end
      'h01: ma = mb;
      'h02: ma = (ma / 16) * 16 + s;
      'h03: ma = im;
      'h04: mb = ma;
      'h05: begin r = mb + im; ocf = r > 255 ? 1 : 0; mb = r % 256; ozf = mb == 0 ? 1 : 0; end
      'h06: mb = (mb / 16) * 16 + s;
      'h07: mb = im;
      'h10: begin ocf = ma < im ? 1 : 0; ma = (ma - im + 256) % 256; ozf = ma == 0 ? 1 : 0; end
      'h11: begin ocf = mb < im ? 1 : 0; mb = (mb - im + 256) % 256; ozf = mb == 0 ? 1 : 0; end
      'h12: begin r = ma + mb; ocf = r > 255 ? 1 : 0; ma = r % 256; ozf = ma == 0 ? 1 : 0; end
`ifdef EXEC_SHIFT_EN
      'h13, 'h14: begin
        n = im % 8;
        if (n != 0) begin
          ocf = op == 'h13 ? (ma >> (8 - n)) % 2 : (ma >> (n - 1)) % 2;
          ma = op == 'h13 ? (ma << n) % 256 : ma >> n;
          cyc = n;
        end
        ozf = ma == 0 ? 1 : 0;
      end
`endif
      default: ;
    endcase
    if ((op == 'h0E && mcf == 0) || op == 'h0F || (op == 'h15 && mzf == 1)) mip = im;
    else mip = (mip + 1) % 256;
    mcf = ocf;
    mzf = ozf;
    return cyc;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int op, input int im, input int s);
    int w = 0;
    while (!instr_ready && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_issue", int'(instr_ready), 1);
    opcode = op[4:0]; imm = im[7:0]; sw = s[3:0]; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic step(input int op, input int im, input int s, output int cyc);
    issue(op, im, s);
    cyc = model(op, im, s);
  endtask

  task automatic chk_regs(input string nm);
    chk({nm, "_a"}, int'(a), ma);
    chk({nm, "_b"}, int'(b), mb);
    chk({nm, "_cf"}, int'(cf), mcf);
    chk({nm, "_zf"}, int'(zf), mzf);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_a"}, int'(a), 0);
    chk({nm, "_b"}, int'(b), 0);
    chk({nm, "_ip"}, int'(ip), 0);
    chk({nm, "_flags"}, int'({cf, zf}), 0);
    chk({nm, "_out_data"}, int'(out_data), 0);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_ready"}, int'(instr_ready), 1);
  endtask

  typedef struct {
    logic [4:0] op;
    logic [7:0] im;
    logic [3:0] s;
    logic [7:0] ea, eb, eip;
    logic ecf, ezf;
  } vec_t;
  vec_t tbl[23];
  int ops[18] = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h09, 'h0B,
                  'h0E, 'h0F, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15};

  initial begin
    int cyc, op, im, s, k;
    tbl[0]  = '{5'h00, 8'hF0, 4'h0, 8'hF0, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{5'h00, 8'h20, 4'h0, 8'h10, 8'h00, 8'h02, 1'b1, 1'b0};
    tbl[2]  = '{5'h0E, 8'h40, 4'h0, 8'h10, 8'h00, 8'h03, 1'b0, 1'b0};
    tbl[3]  = '{5'h03, 8'h05, 4'h0, 8'h05, 8'h00, 8'h04, 1'b0, 1'b0};
    tbl[4]  = '{5'h0E, 8'h40, 4'h0, 8'h05, 8'h00, 8'h40, 1'b0, 1'b0};
    tbl[5]  = '{5'h10, 8'h05, 4'h0, 8'h00, 8'h00, 8'h41, 1'b0, 1'b1};
    tbl[6]  = '{5'h15, 8'h20, 4'h0, 8'h00, 8'h00, 8'h20, 1'b0, 1'b0};
    tbl[7]  = '{5'h11, 8'h01, 4'h0, 8'h00, 8'hFF, 8'h21, 1'b1, 1'b0};
    tbl[8]  = '{5'h03, 8'h37, 4'h0, 8'h37, 8'hFF, 8'h22, 1'b0, 1'b0};
    tbl[9]  = '{5'h02, 8'h00, 4'h9, 8'h39, 8'hFF, 8'h23, 1'b0, 1'b0};
    tbl[10] = '{5'h04, 8'h00, 4'h0, 8'h39, 8'h39, 8'h24, 1'b0, 1'b0};
    tbl[11] = '{5'h12, 8'h00, 4'h0, 8'h72, 8'h39, 8'h25, 1'b0, 1'b0};
    tbl[12] = '{5'h07, 8'h8E, 4'h0, 8'h72, 8'h8E, 8'h26, 1'b0, 1'b0};
    tbl[13] = '{5'h12, 8'h00, 4'h0, 8'h00, 8'h8E, 8'h27, 1'b1, 1'b1};
    tbl[14] = '{5'h01, 8'h00, 4'h0, 8'h8E, 8'h8E, 8'h28, 1'b0, 1'b0};
    tbl[15] = '{5'h06, 8'h00, 4'h3, 8'h8E, 8'h83, 8'h29, 1'b0, 1'b0};
    tbl[16] = '{5'h05, 8'h7D, 4'h0, 8'h8E, 8'h00, 8'h2A, 1'b1, 1'b1};
    tbl[17] = '{5'h15, 8'h77, 4'h0, 8'h8E, 8'h00, 8'h77, 1'b0, 1'b0};
    tbl[18] = '{5'h15, 8'h10, 4'h0, 8'h8E, 8'h00, 8'h78, 1'b0, 1'b0};
    tbl[19] = '{5'h1F, 8'h00, 4'h0, 8'h8E, 8'h00, 8'h79, 1'b0, 1'b0};
    tbl[20] = '{5'h0F, 8'hFF, 4'h0, 8'h8E, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[21] = '{5'h08, 8'h00, 4'h0, 8'h8E, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[22] = '{5'h10, 8'h8F, 4'h0, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("reset_released");

    for (int i = 0; i < 23; i++) begin
      issue(int'(tbl[i].op), int'(tbl[i].im), int'(tbl[i].s));
      chk($sformatf("tbl%0d_a", i), int'(a), int'(tbl[i].ea));
      chk($sformatf("tbl%0d_b", i), int'(b), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_ip", i), int'(ip), int'(tbl[i].eip));
      chk($sformatf("tbl%0d_cf", i), int'(cf), int'(tbl[i].ecf));
      chk($sformatf("tbl%0d_zf", i), int'(zf), int'(tbl[i].ezf));
    end
    ma = 'hFF; mb = 0; mip = 1; mcf = 1; mzf = 0;

    step('h03, 'hA1, 0, cyc);
    step('h13, 3, 0, cyc);
    chk("shl_ip_at_accept", int'(ip), 3);
`ifdef EXEC_SHIFT_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("shl_busy%0d", i), int'(instr_ready), 0);
      @(negedge clk);
    end
    chk("shl_a", int'(a), 'h08);
    chk("shl_cf", int'(cf), 1);
`else
    chk("shl_nop_a", int'(a), 'hA1);
    chk("shl_nop_cf", int'(cf), 0);
`endif
    chk("shl_ready_after", int'(instr_ready), 1);
    step('h14, 'h08, 0, cyc);
`ifdef EXEC_SHIFT_EN
    chk("shr0_a", int'(a), 'h08);
`else
    chk("shr0_a", int'(a), 'hA1);
`endif
    chk("shr0_ip", int'(ip), 4);
    chk("shr0_flags", int'({cf, zf}), 0);
    chk("shr0_ready", int'(instr_ready), 1);

    step('h07, 'h5A, 0, cyc);
    step('h09, 0, 0, cyc);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("outb_valid%0d", i), int'(out_valid), 1);
      chk($sformatf("outb_data%0d", i), int'(out_data), 'h5A);
      chk($sformatf("outb_stall%0d", i), int'(instr_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("outb_valid_drop", int'(out_valid), 0);
    chk("outb_ready_back", int'(instr_ready), 1);
    step('h08, 0, 0, cyc);
    chk("outb_next_ip", int'(ip), 7);

    out_ready = 1'b1;
    step('h0B, 'hC3, 0, cyc);
    chk("outimm_pulse", int'(out_valid), 1);
    chk("outimm_data", int'(out_data), 'hC3);
    @(negedge clk);
    out_ready = 1'b0;
    chk("outimm_drop", int'(out_valid), 0);
    chk("outimm_ready", int'(instr_ready), 1);

    step('h07, 'h11, 0, cyc);
    step('h09, 0, 0, cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_out");
    @(negedge clk);
    rst_n = 1'b1;
    ma = 0; mb = 0; mip = 0; mcf = 0; mzf = 0;
`ifdef EXEC_SHIFT_EN
    step('h03, 'hFF, 0, cyc);
    step('h13, 7, 0, cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid_shift");
    @(negedge clk);
    rst_n = 1'b1;
    ma = 0; mb = 0; mip = 0; mcf = 0; mzf = 0;
`endif

    for (int t = 0; t < 400; t++) begin
      op = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 31)) : ops[$urandom_range(0, 17)];
      im = $urandom_range(0, 255);
      s = $urandom_range(0, 15);
      step(op, im, s, cyc);
      chk("rnd_ip", int'(ip), mip);
      for (int i = 0; i < cyc; i++) begin
        chk("rnd_shift_busy", int'(instr_ready), 0);
        @(negedge clk);
      end
      if (op == 'h09 || op == 'h0B) begin
        k = $urandom_range(0, 3);
        for (int i = 0; i <= k; i++) begin
          chk("rnd_out_valid", int'(out_valid), 1);
          chk("rnd_out_data", int'(out_data), op == 'h0B ? im : mb);
          chk("rnd_out_stall", int'(instr_ready), 0);
          if (i == k) out_ready = 1'b1;
          @(negedge clk);
        end
        out_ready = 1'b0;
        chk("rnd_out_drop", int'(out_valid), 0);
      end
      chk("rnd_ready", int'(instr_ready), 1);
      chk_regs("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
